uart_receiver: RTL and testbench
================================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter: CLOCKS_PER_BAUD, 16, clock cycles per bit period; even integer, minimum 4.
REQ-002 Port: i_CLK  input  1  single system clock; all logic on its rising edge.
REQ-003 Port: i_RESET_N  input  1  reset, asynchronous and active-low; assertion takes effect immediately, release is sampled on i_CLK.
REQ-004 Port: i_RX  input  1  asynchronous serial line; idle high, 8N1, LSB first (the line driven by the team's uart_transmitter o_TX).
REQ-005 Port: o_DATA_OUT  output  8  last correctly framed byte received.
REQ-006 Port: o_RX_VALID  output  1  one-cycle pulse, o_DATA_OUT newly updated.
REQ-007 Port: o_FRAME_ERROR  output  1  one-cycle pulse, stop bit sampled low.
REQ-008 Port: o_RX_BUSY  output  1  high in any state other than IDLE.

Function
REQ-009 i_RX SHALL pass through a 2-flop synchronizer; all other logic uses only the synchronized value.
REQ-010 A third flop SHALL hold the previous synchronized value for falling-edge detection.
REQ-011 States SHALL be IDLE, START, DATA, STOP; a baud counter (0..CLOCKS_PER_BAUD-1) and a 3-bit bit counter SHALL be kept.
REQ-012 IDLE: move to START only on a synchronized high-to-low transition; a line held low does not re-arm. Baud counter cleared.
REQ-013 START: at baud count CLOCKS_PER_BAUD/2-1, if the line is low, go to DATA with both counters cleared; if high, treat as a glitch and go to IDLE with no output pulse.
REQ-014 DATA: at baud count CLOCKS_PER_BAUD-1, sample the line, shift it into bit 7 of the shift register (right shift), clear the baud counter, increment the bit counter; after the 8th sample (bit counter wraps 7->0) go to STOP.
REQ-015 STOP: at baud count CLOCKS_PER_BAUD-1, sample the line and go to IDLE (mid-stop-bit re-arm).
REQ-016 Stop sample high: load o_DATA_OUT from the shift register and pulse o_RX_VALID for exactly one cycle.
REQ-017 Stop sample low: pulse o_FRAME_ERROR for one cycle; o_DATA_OUT holds its previous value; o_RX_VALID stays low.
REQ-018 o_RX_VALID and o_FRAME_ERROR SHALL never be high together, and each SHALL be high for at most one cycle per frame.
REQ-019 Latency: o_RX_VALID goes high 2 + CLOCKS_PER_BAUD/2 + 9*CLOCKS_PER_BAUD rising edges after the first edge that samples i_RX low (154 for the default).
REQ-020 Back-to-back frames, with the next start bit immediately after a one-bit stop, SHALL be received without loss.
REQ-021 The baud counter SHALL be wide enough for CLOCKS_PER_BAUD-1 and SHALL never wrap except through an explicit clear.
REQ-022 o_DATA_OUT and all three output pulses SHALL be registered outputs, with no combinational path from i_RX.

Reset
REQ-023 When i_RESET_N is low, the following SHALL apply asynchronously:
- state = IDLE;
- both counters and the shift register = 0;
- synchronizer and edge flops = 1;
- o_DATA_OUT = 0x00; o_RX_VALID = 0; o_FRAME_ERROR = 0; o_RX_BUSY = 0.
REQ-024 Reset during a frame SHALL abort it with no output pulse; the remainder of that frame is not decoded as a new frame unless a fresh falling edge occurs after release.

Verification
REQ-025 Default parameter; send 0x55 with a valid stop bit -> o_RX_VALID pulses once, 154 edges after the start edge; o_DATA_OUT = 0x55; o_FRAME_ERROR stays 0.
REQ-026 Send 0xA5 then 0x3C back-to-back -> two o_RX_VALID pulses 160 cycles apart; o_DATA_OUT = 0xA5, then 0x3C.
REQ-027 Drive i_RX low for 4 cycles, then high -> o_RX_BUSY rises and returns to 0 within 10 cycles; no o_RX_VALID or o_FRAME_ERROR pulse.
REQ-028 After receiving 0x12, send 0xFF with the stop bit low -> one o_FRAME_ERROR pulse; o_DATA_OUT stays 0x12; with the line then held low 2000 cycles, no further pulses.
REQ-029 Assert i_RESET_N low during data bit 3 of 0x81 -> all outputs 0 immediately; after release and a new 0x81 frame -> o_DATA_OUT = 0x81, one o_RX_VALID pulse.
REQ-030 Loopback with uart_transmitter at a matching bit period, sending bytes 0x00 to 0xFF -> 256 o_RX_VALID pulses, each byte matching, zero frame errors.

Source files
------------

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module   : uart_receiver
// Brief    : 8N1 UART receiver, mid-bit sampling, registered data/pulse outputs
// Revision : 1.0 - initial release
// ============================================================================
module uart_receiver #(
    parameter int CLOCKS_PER_BAUD = 16
) (
    input  logic       i_CLK,
    input  logic       i_RESET_N,
    input  logic       i_RX,
    output logic [7:0] o_DATA_OUT,
    output logic       o_RX_VALID,
    output logic       o_FRAME_ERROR,
    output logic       o_RX_BUSY
);

    localparam int c_CNT_W = (CLOCKS_PER_BAUD > 1) ? $clog2(CLOCKS_PER_BAUD) : 1;
    localparam logic [c_CNT_W-1:0] c_HALF = c_CNT_W'(CLOCKS_PER_BAUD / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(CLOCKS_PER_BAUD - 1);
    localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic               r_sync1;
    logic               r_sync2;
    logic               r_prev;
    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_baud;
    logic [c_CNT_W-1:0] w_baud_nxt;
    logic [2:0]         r_bit;
    logic [2:0]         w_bit_nxt;
    logic [7:0]         r_shift;
    logic [7:0]         w_shift_nxt;
    logic [7:0]         r_data;
    logic [7:0]         w_data_nxt;
    logic               r_valid;
    logic               w_valid_nxt;
    logic               r_ferr;
    logic               w_ferr_nxt;
    logic               w_fall;

    // Only a genuine high-to-low transition arms a frame; a stuck-low line does not
    assign w_fall = r_prev & ~r_sync2;

    always_ff @(posedge i_CLK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_sync1 <= i_RX;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_ferr  <= w_ferr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                w_baud_nxt = '0;
                if (w_fall) begin
                    w_state_nxt = START;
                end
            end
            START: begin
                if (r_baud == c_HALF) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = r_sync2 ? IDLE : DATA;
                end else begin
                    w_baud_nxt = r_baud + c_ONE;
                end
            end
            DATA: begin
                if (r_baud == c_FULL) begin
                    w_baud_nxt  = '0;
                    w_shift_nxt = {r_sync2, r_shift[7:1]};
                    w_bit_nxt   = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = STOP;
                    end
                end else begin
                    w_baud_nxt = r_baud + c_ONE;
                end
            end
            STOP: begin
                // Returning to IDLE mid-stop-bit leaves half a bit to catch the next start edge
                if (r_baud == c_FULL) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = IDLE;
                    if (r_sync2) begin
                        w_data_nxt  = r_shift;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_ferr_nxt = 1'b1;
                    end
                end else begin
                    w_baud_nxt = r_baud + c_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign o_DATA_OUT    = r_data;
    assign o_RX_VALID    = r_valid;
    assign o_FRAME_ERROR = r_ferr;
    assign o_RX_BUSY     = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_receiver
// Brief    : Directed and randomized frame stimulus against a byte-level model
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

    localparam int C = 16;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] data_out;
    logic       rx_valid;
    logic       frame_error;
    logic       rx_busy;

    int         vectors = 0;
    int         errs    = 0;
    int         cyc     = 0;
    int         start_cyc;
    int         fe_cnt    = 0;
    int         both_cnt  = 0;
    int         long_cnt  = 0;
    logic       prev_valid = 1'b0;
    logic       prev_ferr  = 1'b0;
    logic [7:0] vq[$];
    int         vt[$];

    uart_receiver #(.CLOCKS_PER_BAUD(C)) dut (
        .i_CLK         (clk),
        .i_RESET_N     (rst_n),
        .i_RX          (rx),
        .o_DATA_OUT    (data_out),
        .o_RX_VALID    (rx_valid),
        .o_FRAME_ERROR (frame_error),
        .o_RX_BUSY     (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Pulse monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rx_valid) begin
            vq.push_back(data_out);
            vt.push_back(cyc);
        end
        if (frame_error) fe_cnt++;
        if (rx_valid && frame_error) both_cnt++;
        if ((rx_valid && prev_valid) || (frame_error && prev_ferr)) long_cnt++;
        prev_valid = rx_valid;
        prev_ferr  = frame_error;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One 8N1 frame; rst_bit >= 0 pulls reset mid-way through that bit and
    // holds it until data bit 7 (line high) starts
    task automatic send_frame(input logic [7:0] b, input logic stop, input int rst_bit);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        start_cyc = cyc + 1;
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            if (rst_bit >= 0 && i == 8) rst_n = 1'b1;
            if (i == rst_bit) begin
                tick(C / 2);
                chk("busy_before_rst", {31'd0, rx_busy}, 32'd1);
                rst_n = 1'b0;
                #1;
                chk("rst_data", {24'd0, data_out}, 32'd0);
                chk("rst_valid", {31'd0, rx_valid}, 32'd0);
                chk("rst_ferr", {31'd0, frame_error}, 32'd0);
                chk("rst_busy", {31'd0, rx_busy}, 32'd0);
                tick(C / 2);
            end else begin
                tick(C);
            end
        end
    endtask

    function automatic logic [31:0] qget(input int i);
        return (i < vq.size()) ? {24'd0, vq[i]} : 32'hDEAD_BEEF;
    endfunction

    initial begin
        logic [7:0] exp_q[$];
        logic [7:0] last_good;
        int         exp_fe;
        logic [7:0] b;
        logic       stop;

        rst_n = 1'b0;
        rx    = 1'b1;
        tick(5);
        chk("reset_data", {24'd0, data_out}, 32'd0);
        chk("reset_valid", {31'd0, rx_valid}, 32'd0);
        chk("reset_ferr", {31'd0, frame_error}, 32'd0);
        chk("reset_busy", {31'd0, rx_busy}, 32'd0);
        rst_n = 1'b1;
        tick(5);

        // Single frame and latency
        send_frame(8'h55, 1'b1, -1);
        tick(4);
        chk("x55_count", vq.size(), 32'd1);
        chk("x55_data", qget(0), 32'h55);
        chk("x55_latency", (vq.size() > 0) ? vt[0] - start_cyc : -1, 32'd154);
        chk("x55_ferr", fe_cnt, 32'd0);

        // Back-to-back frames
        vq.delete(); vt.delete();
        send_frame(8'hA5, 1'b1, -1);
        send_frame(8'h3C, 1'b1, -1);
        tick(4);
        chk("b2b_count", vq.size(), 32'd2);
        chk("b2b_first", qget(0), 32'hA5);
        chk("b2b_second", qget(1), 32'h3C);
        chk("b2b_spacing", (vq.size() > 1) ? vt[1] - vt[0] : -1, 32'd160);

        // Start-bit glitch
        vq.delete(); vt.delete();
        rx = 1'b0;
        tick(4);
        chk("glitch_busy_high", {31'd0, rx_busy}, 32'd1);
        rx = 1'b1;
        tick(10);
        chk("glitch_busy_low", {31'd0, rx_busy}, 32'd0);
        tick(C);
        chk("glitch_no_valid", vq.size(), 32'd0);
        chk("glitch_no_ferr", fe_cnt, 32'd0);

        // Framing error keeps the previous byte; stuck-low line stays quiet
        send_frame(8'h12, 1'b1, -1);
        send_frame(8'hFF, 1'b0, -1);
        tick(4);
        chk("ferr_count", fe_cnt, 32'd1);
        chk("ferr_valid_count", vq.size(), 32'd1);
        chk("ferr_data_held", {24'd0, data_out}, 32'h12);
        tick(2000);
        chk("stuck_low_ferr", fe_cnt, 32'd1);
        chk("stuck_low_valid", vq.size(), 32'd1);
        rx = 1'b1;
        tick(2 * C);

        // Reset during data bit 3 of 0x81, then a clean 0x81
        vq.delete(); vt.delete();
        fe_cnt = 0;
        send_frame(8'h81, 1'b1, 4);
        tick(2 * C);
        chk("abort_no_valid", vq.size(), 32'd0);
        chk("abort_no_ferr", fe_cnt, 32'd0);
        chk("abort_data", {24'd0, data_out}, 32'd0);
        send_frame(8'h81, 1'b1, -1);
        tick(4);
        chk("after_rst_count", vq.size(), 32'd1);
        chk("after_rst_data", {24'd0, data_out}, 32'h81);

        // Randomized frames with random stop bits and idle gaps
        vq.delete(); vt.delete();
        fe_cnt = 0;
        exp_fe = 0;
        last_good = 8'h81;
        for (int n = 0; n < 40; n++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            send_frame(b, stop, -1);
            if (stop) begin
                exp_q.push_back(b);
                last_good = b;
            end else begin
                exp_fe++;
            end
            rx = 1'b1;
            // After a low stop bit the line must go high before a new start edge exists
            tick(stop ? $urandom_range(0, 2 * C) : C + $urandom_range(0, C));
        end
        tick(4);
        chk("rand_count", vq.size(), exp_q.size());
        foreach (exp_q[i]) chk("rand_byte", qget(i), {24'd0, exp_q[i]});
        chk("rand_ferr", fe_cnt, exp_fe);
        chk("rand_last_data", {24'd0, data_out}, {24'd0, last_good});

        // Full byte sweep, back-to-back
        vq.delete(); vt.delete();
        fe_cnt = 0;
        for (int n = 0; n < 256; n++) send_frame(8'(n), 1'b1, -1);
        tick(4);
        chk("sweep_count", vq.size(), 32'd256);
        for (int n = 0; n < 256; n++) chk("sweep_byte", qget(n), n);
        chk("sweep_ferr", fe_cnt, 32'd0);

        chk("never_both", both_cnt, 32'd0);
        chk("single_cycle_pulses", long_cnt, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
`default_nettype wire
